// File: rtl/ghost_move_scheduler_pkg.sv
// rtl/ghost_move_scheduler_pkg.sv - shared constants and state encoding for the ghost move scheduler
package ghost_sched_pkg;

    localparam int OFF_W   = 26;
    localparam int SCORE_W = 14;
    localparam int Y_W     = 10;

    localparam logic [Y_W-1:0] ZONE_Y = 10'd297;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_FREEZE = 2'd2
    } state_t;

endpackage

// File: rtl/ghost_move_scheduler_if.sv
// rtl/ghost_move_scheduler_if.sv - game-side bundle between score/collision logic and the scheduler
interface ghost_move_scheduler_if
    import ghost_sched_pkg::*;
#(
    parameter int N_GHOST = 4
);
    logic               start;
    logic               collision;
    logic [SCORE_W-1:0] score;
    logic [Y_W-1:0]     y_y;
    logic [N_GHOST-1:0] move_en;
    logic [N_GHOST-1:0] chase_en;
    logic [OFF_W-1:0]   speed_offset;
    logic [1:0]         state;

    modport master (
        output start, collision, score, y_y,
        input  move_en, chase_en, speed_offset, state
    );

    modport slave (
        input  start, collision, score, y_y,
        output move_en, chase_en, speed_offset, state
    );

endinterface

// File: rtl/ghost_move_scheduler_tick_timer.sv
// rtl/ghost_move_scheduler_tick_timer.sv - score-scaled period counter producing the sweep tick
module ghost_tick_timer
    import ghost_sched_pkg::*;
#(
    parameter int TIME_MAX   = 4600000,
    parameter int SPEED_STEP = 2000,
    parameter int OFFSET_MAX = 3000000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               run,
    input  logic [SCORE_W-1:0] score,
    output logic               tick,
    output logic [OFF_W-1:0]   speed_offset
);

    localparam int PROD_W = SCORE_W + 32;

    logic [PROD_W-1:0] prod;
    logic [OFF_W-1:0]  prod_sat;
    logic [OFF_W-1:0]  offset_next;
    logic [OFF_W-1:0]  period;
    logic [OFF_W-1:0]  count;

    // Saturate into 26 bits before the clamp so a huge product cannot alias small.
    assign prod        = PROD_W'(score) * PROD_W'(SPEED_STEP);
    assign prod_sat    = (prod > PROD_W'({OFF_W{1'b1}})) ? {OFF_W{1'b1}} : prod[OFF_W-1:0];
    assign offset_next = (prod_sat > OFF_W'(OFFSET_MAX)) ? OFF_W'(OFFSET_MAX) : prod_sat;

    assign period = OFF_W'(TIME_MAX) - speed_offset;
    // >= rather than == so a period shrinking under the count still ticks at once.
    assign tick   = run && (count >= period - OFF_W'(1));

    always_ff @(posedge clk) begin
        if (reset) begin
            speed_offset <= '0;
        end else begin
            speed_offset <= offset_next;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || !run || tick) begin
            count <= '0;
        end else begin
            count <= count + OFF_W'(1);
        end
    end

endmodule

// File: rtl/ghost_move_scheduler.sv
// rtl/ghost_move_scheduler.sv - run/freeze FSM, round-robin move sweep and zone-gated chase enables
module ghost_move_scheduler
    import ghost_sched_pkg::*;
#(
    parameter int                 N_GHOST       = 4,
    parameter int                 TIME_MAX      = 4600000,
    parameter int                 SPEED_STEP    = 2000,
    parameter int                 OFFSET_MAX    = 3000000,
    parameter int                 FREEZE_CYCLES = 50000000,
    parameter logic [N_GHOST-1:0] ZONE_MAP      = 4'b1010
) (
    input  logic                   clk,
    input  logic                   reset,
    ghost_move_scheduler_if.slave  bus
);

    localparam int IDX_W = $clog2(N_GHOST + 1);

    state_t             state;
    state_t             next_state;
    logic               run;
    logic               tick;
    logic [OFF_W-1:0]   timer;
    logic [IDX_W-1:0]   sweep_idx;
    logic               sweep_active;
    logic [N_GHOST-1:0] sweep_dec;
    logic [N_GHOST-1:0] move_en;
    logic [N_GHOST-1:0] chase_en;
    logic               in_bottom;

    // A collision suppresses the tick in the same cycle and clears the counter.
    assign run = (state == S_RUN) && !bus.collision;

    ghost_tick_timer #(
        .TIME_MAX   (TIME_MAX),
        .SPEED_STEP (SPEED_STEP),
        .OFFSET_MAX (OFFSET_MAX)
    ) u_tick_timer (
        .clk          (clk),
        .reset        (reset),
        .run          (run),
        .score        (bus.score),
        .tick         (tick),
        .speed_offset (bus.speed_offset)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:   if (bus.start) next_state = S_RUN;
            S_RUN:    if (bus.collision) next_state = S_FREEZE;
            S_FREEZE: if (!bus.collision && timer == '0) next_state = S_RUN;
            default:  next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            timer <= '0;
        end else if (bus.collision && next_state == S_FREEZE) begin
            timer <= OFF_W'(FREEZE_CYCLES - 1);
        end else if (state == S_FREEZE && timer != '0) begin
            timer <= timer - OFF_W'(1);
        end else if (state != S_FREEZE) begin
            timer <= '0;
        end
    end

    always_comb begin
        sweep_dec = '0;
        for (int i = 0; i < N_GHOST; i++) begin
            sweep_dec[i] = (sweep_idx == IDX_W'(i));
        end
    end

    // Leaving RUN for any reason aborts the sweep; unserved ghosts simply miss this round.
    always_ff @(posedge clk) begin
        if (reset || next_state != S_RUN) begin
            move_en      <= '0;
            sweep_idx    <= '0;
            sweep_active <= 1'b0;
        end else if (tick) begin
            move_en      <= N_GHOST'(1);
            sweep_idx    <= IDX_W'(1);
            sweep_active <= (N_GHOST > 1);
        end else if (sweep_active) begin
            move_en      <= sweep_dec;
            sweep_idx    <= sweep_idx + IDX_W'(1);
            sweep_active <= (sweep_idx != IDX_W'(N_GHOST - 1));
        end else begin
            move_en   <= '0;
            sweep_idx <= '0;
        end
    end

    assign in_bottom = (bus.y_y >= ZONE_Y);

    always_ff @(posedge clk) begin
        if (reset) begin
            chase_en <= '0;
        end else begin
            for (int i = 0; i < N_GHOST; i++) begin
                chase_en[i] <= (next_state == S_RUN) && (in_bottom == ZONE_MAP[i]);
            end
        end
    end

    assign bus.move_en  = move_en;
    assign bus.chase_en = chase_en;
    assign bus.state    = state;

endmodule

// File: tb/tb_ghost_move_scheduler.sv
// tb/tb_ghost_move_scheduler.sv - scoreboard bench for ghost_move_scheduler against a behavioural model
module tb_ghost_move_scheduler;
    import ghost_sched_pkg::*;

    localparam int          NG = 4;
    localparam int          TM = 20;
    localparam int          SS = 2;
    localparam int          OM = 10;
    localparam int          FC = 8;
    localparam logic [3:0]  ZM = 4'b1010;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    ghost_move_scheduler_if #(.N_GHOST(NG)) bus ();

    ghost_move_scheduler #(
        .N_GHOST       (NG),
        .TIME_MAX      (TM),
        .SPEED_STEP    (SS),
        .OFFSET_MAX    (OM),
        .FREEZE_CYCLES (FC),
        .ZONE_MAP      (ZM)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [1:0]  st;
        logic [3:0]  mv;
        logic [3:0]  ch;
        logic [25:0] off;
    } exp_t;

    exp_t sbq[$];
    int   compared   = 0;
    int   mismatched = 0;

    // Model: game mode, elapsed cycles in the period, remaining freeze cycles,
    // and a queue of ghosts still owed a strobe in the current sweep.
    int         m_mode = 0;
    int         m_cnt = 0;
    int         m_off = 0;
    int         m_left = 0;
    int         owed[$];
    logic [3:0] m_last_mv = '0;
    logic [3:0] zm_v = ZM;

    task automatic chk(input string name, input logic [25:0] act, input logic [25:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        exp_t e;
        int   period;
        int   new_off;
        int   ghost;
        longint prod;
        e.mv = '0;
        e.ch = '0;
        prod = longint'(bus.score) * SS;
        new_off = (prod > OM) ? OM : int'(prod);
        period = TM - m_off;
        if (reset) begin
            m_mode = 0; m_cnt = 0; m_left = 0; new_off = 0;
            owed.delete();
        end else begin
            case (m_mode)
                0: if (bus.start) begin m_mode = 1; m_cnt = 0; end
                1: begin
                    if (bus.collision) begin
                        m_mode = 2; m_left = FC; m_cnt = 0;
                        owed.delete();
                    end else begin
                        if (m_cnt + 1 >= period) begin
                            m_cnt = 0;
                            for (int g = 0; g < NG; g++) owed.push_back(g);
                        end else begin
                            m_cnt++;
                        end
                        if (owed.size() > 0) begin
                            ghost = owed.pop_front();
                            e.mv[ghost] = 1'b1;
                        end
                    end
                end
                default: begin
                    if (bus.collision) m_left = FC;
                    else if (m_left <= 1) begin m_mode = 1; m_cnt = 0; end
                    else m_left--;
                end
            endcase
        end
        m_off = new_off;
        if (m_mode == 1)
            for (int g = 0; g < NG; g++) e.ch[g] = ((bus.y_y >= 10'd297) == zm_v[g]);
        e.st  = 2'(m_mode);
        e.off = 26'(m_off);
        m_last_mv = e.mv;
        sbq.push_back(e);
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (sbq.size() > 0) begin
            e = sbq.pop_front();
            chk("state", 26'(bus.state), 26'(e.st));
            chk("move_en", 26'(bus.move_en), 26'(e.mv));
            chk("chase_en", 26'(bus.chase_en), 26'(e.ch));
            chk("speed_offset", bus.speed_offset, e.off);
        end
    end

    initial begin
        bus.start = 1'b0;
        bus.collision = 1'b0;
        bus.score = '0;
        bus.y_y = 10'd100;
        reset = 1'b1;
        repeat (3) cycle();
        reset = 1'b0;

        for (int k = 0; k < 100; k++) begin
            bus.y_y = 10'($urandom_range(250, 350));
            cycle();
        end

        bus.y_y = 10'd296;
        bus.start = 1'b1;
        cycle();
        bus.start = 1'b0;
        repeat (60) cycle();
        bus.y_y = 10'd297;
        bus.score = 14'd3;
        repeat (40) cycle();
        bus.score = 14'd9;
        repeat (40) cycle();

        bus.score = 14'd0;
        repeat (3) cycle();
        for (int k = 0; k < 100 && m_cnt != 15; k++) cycle();
        bus.score = 14'd5;
        repeat (5) cycle();
        bus.score = 14'd0;

        for (int k = 0; k < 100 && m_last_mv != 4'b0010; k++) cycle();
        bus.collision = 1'b1;
        cycle();
        bus.collision = 1'b0;
        repeat (40) cycle();

        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 29) == 0) bus.score = 14'($urandom_range(0, 15));
            if ($urandom_range(0, 499) == 0) bus.score = 14'h3fff;
            bus.y_y       = 10'($urandom_range(285, 310));
            bus.start     = ($urandom_range(0, 19) == 0);
            bus.collision = ($urandom_range(0, 59) == 0);
            reset         = ($urandom_range(0, 599) == 0);
            cycle();
        end
        reset = 1'b0;
        bus.start = 1'b0;
        bus.collision = 1'b0;
        repeat (4) cycle();
        @(negedge clk);
        #1;
        compared++;
        if (sbq.size() != 0) begin
            mismatched++;
            $display("FAIL drain: got %0d pending expected 0", sbq.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/ghost_move_scheduler.md
# ghost_move_scheduler

Central controller that sequences ghost motion for all ghost sprite blocks. It derives a score-dependent move period, issues one-cycle move strobes to each ghost in round-robin order after every period, and gates each ghost's chase permission by Yoshi's screen zone. It also freezes all ghosts for a fixed interval after a collision. It sits between score/collision logic and the ghost sprite instances, replacing their private free-running tick counters.

## Interface
Parameters:
- `N_GHOST`, 4: number of ghost instances served.
- `TIME_MAX`, 4600000: base move period in clk cycles, at score 0.
- `SPEED_STEP`, 2000: period reduction per score point.
- `OFFSET_MAX`, 3000000: clamp on total reduction. Must satisfy `OFFSET_MAX <= TIME_MAX - 2*N_GHOST`.
- `FREEZE_CYCLES`, 50000000: freeze length after a collision.
- `ZONE_MAP`, 4'b1010: bit i = 1 means ghost i owns the bottom zone; 0 means the top zone.

Ports:
- `clk`, in, 1: system clock. Single clock domain.
- `reset`, in, 1: synchronous, active-high reset.
- `start`, in, 1: game-start pulse.
- `collision`, in, 1: Yoshi–ghost hit, level or pulse.
- `score`, in, 14: current score, unsigned.
- `y_y`, in, 10: Yoshi top-left y pixel.
- `move_en`, out, N_GHOST: one-hot, one-cycle move strobe per ghost.
- `chase_en`, out, N_GHOST: level; ghost i may chase when high.
- `speed_offset`, out, 26: registered period reduction.
- `state`, out, 2: current FSM state.

## Operation
- FSM states: IDLE=0, RUN=1, FREEZE=2. Encoding 3 is unused and recovers to IDLE.
- IDLE:
  - Period counter, sweep index, and freeze timer are held at 0.
  - `move_en` = 0 and `chase_en` = 0.
  - `start` moves the FSM to RUN.
- RUN:
  - `period = TIME_MAX - speed_offset`.
  - The counter increments each cycle. When `count >= period-1`, the counter wraps to 0 and a sweep begins.
  - A sweep asserts `move_en[i]` for exactly one cycle each, for i = 0..N_GHOST-1, on consecutive cycles. At most one bit is high at any time.
- Sweep vs period: a new tick arriving while a sweep is still active cannot occur, because the period is at least 2*N_GHOST.
- `speed_offset` = min(`score`*SPEED_STEP, OFFSET_MAX):
  - Computed in 26 bits, with the product saturated before the compare.
  - Registered, so it updates 1 cycle after `score` changes.
  - If the period shrinks below the current count, the `>=` compare causes a tick on the next cycle. No missed tick, no counter wrap-around.
- `chase_en[i]`:
  - Registered.
  - High only in RUN and only when `(y_y >= 297) == ZONE_MAP[i]`.
- `collision` in RUN:
  - Next state is FREEZE.
  - Any in-progress sweep is aborted; remaining ghosts get no strobe.
  - The counter is cleared.
  - The timer is loaded with FREEZE_CYCLES-1.
- FREEZE:
  - `move_en` = 0 and `chase_en` = 0.
  - The timer decrements each cycle. When it reaches 0, the FSM returns to RUN with the counter at 0.
  - `collision` reloads the timer.
  - `start` is ignored.
- Simultaneous events:
  - `collision` in the same cycle as a tick: collision wins; no `move_en` is issued.
  - `start` and `collision` together in IDLE: go to RUN (collision is ignored in IDLE).
- `reset` at any time takes effect at the next clk edge. All state and outputs are cleared and the FSM enters IDLE.

## Timing
- Reset values:
  - `state` = IDLE
  - `move_en` = 0
  - `chase_en` = 0
  - `speed_offset` = 0
  - all counters = 0
- `start` sampled at edge t gives `state` = RUN from t+1. The first tick occurs when `count` reaches `period-1`, which is `period` cycles after entering RUN.
- A tick detected at edge t gives `move_en[i]` high during cycle t+1+i.
- Freeze duration: exactly FREEZE_CYCLES cycles in FREEZE, measured from the last collision.
- All outputs are registered. There is no combinational path from any input to any output.

## Structure
- Package `ghost_sched_pkg` holds:
  - the state encoding constants
  - `ZONE_Y = 297`
  - `OFF_W = 26`
  - `SCORE_W = 14`
- Sub-module `ghost_tick_timer` holds the period counter, the compare logic, and the `speed_offset` saturating multiply/clamp register. It outputs a `tick` pulse and takes an enable/clear input from the FSM.
- The top level contains the FSM, sweep index, freeze timer, one-hot decoder, and zone compare.

## Test plan
Use small parameters: TIME_MAX=20, SPEED_STEP=2, OFFSET_MAX=10, FREEZE_CYCLES=8, N_GHOST=4.
- Reset, then hold `start` = 0 for 100 cycles → `state` = 0 and `move_en` = 0 throughout.
- `start` with `score` = 0 → ticks every 20 cycles. After each tick, `move_en` = 0001, 0010, 0100, 1000 on 4 consecutive cycles.
- `score` = 3 → `speed_offset` = 6 one cycle later, period 14. `score` = 9 → `speed_offset` clamps to 10, period 10.
- Count at 15 with period 20, then `score` switches to 5 → tick on the next cycle.
- `collision` on the cycle `move_en` = 0010 → no 0100 or 1000 strobes. `state` = 2 for 8 cycles, then 1; the next tick follows 20 cycles later.
- `y_y` = 296 → `chase_en` = 0101. `y_y` = 297 → `chase_en` = 1010. In FREEZE → `chase_en` = 0000.
